// File: rtl/serial_to_parallel_pkg.sv
// rtl/serial_to_parallel_pkg.sv - shared FSM encoding and counter sizing for the deserialiser
package serial_to_parallel_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } s2p_state_t;

    // Bit counter width; held at 1 so a degenerate width never yields a zero-width vector.
    function automatic int s2p_cnt_width(input int data_size);
        return (data_size > 2) ? $clog2(data_size) : 1;
    endfunction

endpackage

// File: rtl/s2p_shift_reg.sv
// rtl/s2p_shift_reg.sv - enabled shift register with selectable bit order
// o_next is the value the register takes if the current bit is sampled.
module s2p_shift_reg #(
    parameter int DATA_SIZE = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_bit,
    output logic [DATA_SIZE-1:0] o_next
);

    logic [DATA_SIZE-1:0] r_sreg;
    logic [DATA_SIZE-1:0] w_next;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_next = {r_sreg[DATA_SIZE-2:0], i_bit};
        end else begin : g_lsb_first
            assign w_next = {i_bit, r_sreg[DATA_SIZE-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (i_en) begin
            r_sreg <= w_next;
        end
    end

    assign o_next = w_next;

endmodule

// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - 1-bit stream to DATA_SIZE-bit word deserialiser with short-frame detection
// Optional ready/overrun handshake on the word output: SERIAL_TO_PARALLEL_HANDSHAKE_EN.
module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_i,
    input  logic                 valid_i,
`ifdef SERIAL_TO_PARALLEL_HANDSHAKE_EN
    input  logic                 ready_i,
    output logic                 overrun_o,
`endif
    output logic [DATA_SIZE-1:0] parallel_o,
    output logic                 data_valid_o,
    output logic                 frame_err_o,
    output logic                 busy
);

    localparam int            CW       = s2p_cnt_width(DATA_SIZE);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_SIZE - 1);

    s2p_state_t           r_state;
    s2p_state_t           w_state_next;
    logic [CW-1:0]        r_cnt;
    logic [DATA_SIZE-1:0] r_parallel;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic [DATA_SIZE-1:0] w_shift_next;
    logic                 w_busy;
    logic                 w_last;
    logic                 w_abort;

    s2p_shift_reg #(
        .DATA_SIZE (DATA_SIZE),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk    (clk),
        .rst    (rst),
        .i_en   (valid_i),
        .i_bit  (serial_i),
        .o_next (w_shift_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    w_state_next = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (!valid_i || (r_cnt == LAST_CNT)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_last  = 1'b0;
        w_abort = 1'b0;
        if (r_state == ST_RECEIVE) begin
            w_busy  = 1'b1;
            w_last  = valid_i && (r_cnt == LAST_CNT);
            w_abort = !valid_i;
        end
    end

    // The counter sits at zero in IDLE, so the first sampled bit lands it on 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_last || w_abort) begin
            r_cnt <= '0;
        end else if (valid_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef SERIAL_TO_PARALLEL_HANDSHAKE_EN
    logic r_overrun;
    logic w_xfer;

    assign w_xfer = r_data_valid && ready_i;

    // A completing word only replaces the pending one if that one leaves this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parallel   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_abort;
            r_overrun   <= w_last && r_data_valid && !w_xfer;
            if (w_last && (!r_data_valid || w_xfer)) begin
                r_parallel   <= w_shift_next;
                r_data_valid <= 1'b1;
            end else if (w_xfer) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign overrun_o = r_overrun;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parallel   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err  <= w_abort;
            r_data_valid <= w_last;
            if (w_last) begin
                r_parallel <= w_shift_next;
            end
        end
    end
`endif

    assign parallel_o   = r_parallel;
    assign data_valid_o = r_data_valid;
    assign frame_err_o  = r_frame_err;
    assign busy         = w_busy;

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb/tb_serial_to_parallel.sv - table-driven bench for serial_to_parallel, MSB-first and LSB-first instances
module tb_serial_to_parallel;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_i;
    logic       valid_i;
    logic [7:0] pm, pl;
    logic       dvm, dvl, em, el, bm, bl;
`ifdef SERIAL_TO_PARALLEL_HANDSHAKE_EN
    logic       ready_i;
    logic       ovm, ovl;
`endif

    always #5 clk = ~clk;

    serial_to_parallel #(.DATA_SIZE(8), .MSB_FIRST(1'b1)) u_msb (
        .clk          (clk),
        .rst          (rst),
        .serial_i     (serial_i),
        .valid_i      (valid_i),
`ifdef SERIAL_TO_PARALLEL_HANDSHAKE_EN
        .ready_i      (ready_i),
        .overrun_o    (ovm),
`endif
        .parallel_o   (pm),
        .data_valid_o (dvm),
        .frame_err_o  (em),
        .busy         (bm)
    );

    serial_to_parallel #(.DATA_SIZE(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk          (clk),
        .rst          (rst),
        .serial_i     (serial_i),
        .valid_i      (valid_i),
`ifdef SERIAL_TO_PARALLEL_HANDSHAKE_EN
        .ready_i      (ready_i),
        .overrun_o    (ovl),
`endif
        .parallel_o   (pl),
        .data_valid_o (dvl),
        .frame_err_o  (el),
        .busy         (bl)
    );

    typedef struct {
        logic       rst;
        logic       valid;
        logic       sdata;
        logic       busy;
        logic       dv;
        logic       err;
        logic [7:0] pm;
        logic [7:0] pl;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] cur_m, cur_l;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic r, input logic v, input logic s, input logic b,
                        input logic dv, input logic e, input logic [7:0] m, input logic [7:0] l);
        vec_t x;
        x.rst = r; x.valid = v; x.sdata = s; x.busy = b; x.dv = dv; x.err = e; x.pm = m; x.pl = l;
        vecs.push_back(x);
    endtask

    // One full word, bits sent in the listed order (bits[7] first); m/l are the hand-computed words.
    task automatic push_frame(input logic [7:0] bits, input logic [7:0] m, input logic [7:0] l);
        for (int i = 0; i < 8; i++) begin
            push(1'b0, 1'b1, bits[7-i], (i < 7), (i == 7), 1'b0,
                 (i == 7) ? m : cur_m, (i == 7) ? l : cur_l);
        end
        cur_m = m;
        cur_l = l;
    endtask

    task automatic push_partial(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            push(1'b0, 1'b1, bits[7-i], 1'b1, 1'b0, 1'b0, cur_m, cur_l);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         seen;
        int         cyc;
        logic [7:0] w;

        rst = 1'b1; valid_i = 1'b0; serial_i = 1'b0;
`ifdef SERIAL_TO_PARALLEL_HANDSHAKE_EN
        ready_i = 1'b1;
`endif
        cur_m = 8'h00; cur_l = 8'h00;

        push(1'b1, 1'b0, 1'b0, 0, 0, 0, 8'h00, 8'h00);
        push(1'b1, 1'b0, 1'b0, 0, 0, 0, 8'h00, 8'h00);
        push_frame(8'b1100_0000, 8'hC0, 8'h03);
        push(1'b0, 1'b0, 1'b0, 0, 0, 0, cur_m, cur_l);
        push_frame(8'h12, 8'h12, 8'h48);
        push_frame(8'h34, 8'h34, 8'h2C);
        push(1'b0, 1'b0, 1'b0, 0, 0, 0, cur_m, cur_l);
        push_frame(8'b1100_0000, 8'hC0, 8'h03);
        push_partial(8'b1010_1000, 5);
        push(1'b0, 1'b0, 1'b0, 0, 0, 1, cur_m, cur_l);
        push(1'b0, 1'b0, 1'b0, 0, 0, 0, cur_m, cur_l);
        push_partial(8'b1110_0000, 3);
        push(1'b1, 1'b1, 1'b1, 0, 0, 0, 8'h00, 8'h00);
        cur_m = 8'h00; cur_l = 8'h00;
        push_frame(8'h5A, 8'h5A, 8'h5A);
        push_partial(8'b1110_0000, 3);
        push(1'b0, 1'b0, 1'b0, 0, 0, 1, cur_m, cur_l);
        push(1'b0, 1'b0, 1'b0, 0, 0, 0, cur_m, cur_l);

        foreach (vecs[k]) begin
            rst      = vecs[k].rst;
            valid_i  = vecs[k].valid;
            serial_i = vecs[k].sdata;
            tick();
            check($sformatf("v%0d busy", k), bm, vecs[k].busy);
            check($sformatf("v%0d data_valid", k), dvm, vecs[k].dv);
            check($sformatf("v%0d frame_err", k), em, vecs[k].err);
            check($sformatf("v%0d parallel_msb", k), pm, vecs[k].pm);
            check($sformatf("v%0d parallel_lsb", k), pl, vecs[k].pl);
            check($sformatf("v%0d dv_lsb", k), dvl, vecs[k].dv);
            check($sformatf("v%0d dv_err_excl", k), dvm & em, 1'b0);
        end

        // Bounded wait for the completion pulse of 0xB1 (LSB-first view 0x8D).
        w = 8'hB1; seen = 1'b0; cyc = 0;
        while (!seen && cyc < 20) begin
            valid_i  = (cyc < 8);
            serial_i = (cyc < 8) ? w[7 - cyc] : 1'b0;
            tick();
            cyc++;
            seen = dvm;
        end
        valid_i = 1'b0;
        check("b1 seen", seen, 1'b1);
        check("b1 latency", cyc, 8);
        check("b1 msb", pm, 8'hB1);
        check("b1 lsb", pl, 8'h8D);
        tick();
        check("b1 pulse_end", dvm, 1'b0);

`ifdef SERIAL_TO_PARALLEL_HANDSHAKE_EN
        ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w = (i < 8) ? 8'hAA : 8'h55;
            valid_i  = 1'b1;
            serial_i = w[7 - (i % 8)];
            tick();
            if (i == 7) begin
                check("hs aa dv", dvm, 1'b1);
                check("hs aa data", pm, 8'hAA);
            end
        end
        valid_i = 1'b0;
        check("hs overrun", ovm, 1'b1);
        check("hs dv held", dvm, 1'b1);
        check("hs kept msb", pm, 8'hAA);
        check("hs kept lsb", pl, 8'h55);
        tick();
        check("hs overrun_end", ovm, 1'b0);
        check("hs dv still", dvm, 1'b1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("hs xfer clear", dvm, 1'b0);
        check("hs xfer data", pm, 8'hAA);
        ready_i = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Receive-side counterpart of the team's parallel-to-serial converter. Deserialises a 1-bit stream into DATA_SIZE-bit words. Bits are sampled on every clock while a frame-valid strobe is high, so the transmitter's busy output drives valid_i directly. Bit order is selectable, and short frames are detected and flagged.

Parameters:
DATA_SIZE, 8, word width in bits; must be >= 2
MSB_FIRST, 1, 1: first received bit becomes bit DATA_SIZE-1; 0: first received bit becomes bit 0

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
serial_i  input  1  serial data, sampled on clk rising edge when valid_i=1
valid_i  input  1  frame strobe; high for exactly DATA_SIZE consecutive cycles per word
parallel_o  output  DATA_SIZE  last completed word; held until the next word completes
data_valid_o  output  1  new word on parallel_o
frame_err_o  output  1  one-cycle pulse: valid_i fell before DATA_SIZE bits were received
busy  output  1  high while a word is partially received

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, counter=0, shift register=0, parallel_o=0, data_valid_o=0, frame_err_o=0, busy=0. A reset mid-frame discards the partial word.
- Counter width is $clog2(DATA_SIZE). It counts bits received in the current word.
- Shift rule when a bit is sampled:
  - MSB_FIRST=1: sreg <= {sreg[DATA_SIZE-2:0], serial_i}.
  - MSB_FIRST=0: sreg <= {serial_i, sreg[DATA_SIZE-1:1]}.
- FSM states: IDLE, RECEIVE.
- IDLE:
  - valid_i=1: sample bit, counter<=1, go to RECEIVE.
  - Otherwise hold.
  - busy=0.
- RECEIVE (busy=1):
  - valid_i=1 and counter<DATA_SIZE-1: sample bit, counter++.
  - valid_i=1 and counter==DATA_SIZE-1 (last bit): at that edge, load parallel_o with the completed word (shift result including this bit), set data_valid_o=1, counter<=0, go to IDLE.
  - valid_i=0: abort. At that edge set frame_err_o=1, counter<=0, go to IDLE. parallel_o is unchanged and data_valid_o is not asserted.
- Latency: data_valid_o is high in the cycle immediately after the edge that sampled the last bit. It is a 1-cycle pulse and is cleared on the next edge.
- Back-to-back words: if valid_i stays high, IDLE samples the first bit of the next word on the following edge. No bit is lost, and busy is low for exactly that one cycle.
- frame_err_o and data_valid_o are never high in the same cycle.
- valid_i high longer than DATA_SIZE cycles: each further group of DATA_SIZE bits forms a new word. A trailing partial group raises frame_err_o when valid_i falls.

Optional Feature:
Macro SERIAL_TO_PARALLEL_HANDSHAKE_EN.
- Defined:
  - Adds ports ready_i (input, 1) and overrun_o (output, 1).
  - data_valid_o becomes a level. It stays high, with parallel_o stable, until a cycle with data_valid_o=1 and ready_i=1 (transfer). It is cleared on the edge after the transfer.
  - A word completing while an untransferred word is pending, with no transfer in the same cycle, is dropped. The old word is kept and overrun_o pulses for 1 cycle.
  - Completion coinciding with a transfer: the new word is loaded and data_valid_o stays high.
  - Reset clears overrun_o.
- Undefined: no ready_i or overrun_o ports; data_valid_o is a 1-cycle pulse as above.

Decomposition:
- Shared package/header: FSM state encoding (IDLE=1'b0, RECEIVE=1'b1) and the counter-width localparam expression.
- One natural sub-module: s2p_shift_reg. It holds the parameterised shift register with enable and bit-order selection; the FSM, counter and output register stay in the top module.

Test Plan:
1. DATA_SIZE=8, MSB_FIRST=1; valid_i high 8 cycles with bits 1,1,0,0,0,0,0,0 -> parallel_o=0xC0; data_valid_o high exactly 1 cycle after the 8th sampling edge; busy high 7 cycles.
2. MSB_FIRST=0, same bit sequence -> parallel_o=0x03.
3. MSB_FIRST=1; valid_i high 16 consecutive cycles carrying 0x12 then 0x34 -> two data_valid_o pulses 8 cycles apart with 0x12, then 0x34; busy low exactly 1 cycle between words.
4. After 0xC0 is received, valid_i drops after 5 bits -> frame_err_o pulses 1 cycle; no data_valid_o; parallel_o stays 0xC0.
5. rst asserted after 3 bits of a frame -> all outputs 0 on the next cycle; a following full frame 0x5A gives parallel_o=0x5A.
6. With SERIAL_TO_PARALLEL_HANDSHAKE_EN, ready_i=0:
   - Words 0xAA then 0x55 received -> data_valid_o held with 0xAA; overrun_o pulses at the 0x55 completion; 0x55 is dropped.
   - ready_i=1 for 1 cycle -> transfer, data_valid_o low next cycle.
